// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronizes a raw switch level, qualifies it with an
// enable-gated stability counter, and emits registered level plus edge pulses.
module switch_debouncer #(
  parameter int Width      = 20,
  parameter int SyncStages = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic In,
  output logic Out,
  output logic Rise,
  output logic Fall
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic [Width-1:0]      cnt_q, cnt_d;
  logic                  out_q, out_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  sync_s;

  assign sync_s = sync_q[SyncStages-1];

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], In};
  end

  // Any agreement with the current output restarts qualification; the
  // all-ones count always ends in an output update, so the counter never wraps.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_s == out_q) begin
      cnt_d = '0;
    end else if (Enable) begin
      if (cnt_q == {Width{1'b1}}) begin
        out_d  = sync_s;
        cnt_d  = '0;
        rise_d = sync_s;
        fall_d = ~sync_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign Out  = out_q;
  assign Rise = rise_q;
  assign Fall = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed latency scenarios plus randomized
// stimulus compared every cycle against a behavioural reference model.
module tb_switch_debouncer;

  localparam int W  = 3;
  localparam int SS = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Enable = 1'b0;
  logic In = 1'b0;
  logic Out, Rise, Fall;

  int checks = 0;
  int errors = 0;

  // Reference model: In delayed by SS samples, and a run length of enabled
  // disagreeing cycles; the output flips on the 2^W-th such cycle.
  logic m_pipe [SS];
  int   m_run = 0;
  logic m_out = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;

  switch_debouncer #(.Width(W), .SyncStages(SS)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Enable(Enable),
    .In    (In),
    .Out   (Out),
    .Rise  (Rise),
    .Fall  (Fall)
  );

  always #5 Clock = ~Clock;

  task automatic model_edge(input logic rst, input logic en, input logic din);
    logic s;
    if (rst) begin
      for (int k = 0; k < SS; k++) m_pipe[k] = 1'b0;
      m_run = 0; m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    end else begin
      s = m_pipe[SS-1];
      for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = din;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s == m_out) begin
        m_run = 0;
      end else if (en) begin
        m_run++;
        if (m_run == (1 << W)) begin
          m_out  = s;
          m_rise = s;
          m_fall = ~s;
          m_run  = 0;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic din);
    Reset = rst; Enable = en; In = din;
    @(posedge Clock);
    model_edge(rst, en, din);
    #1;
    checks++;
    assert (Out === m_out) else begin
      errors++; $error("FAIL out: got %b expected %b", Out, m_out);
    end
    checks++;
    assert (Rise === m_rise) else begin
      errors++; $error("FAIL rise: got %b expected %b", Rise, m_rise);
    end
    checks++;
    assert (Fall === m_fall) else begin
      errors++; $error("FAIL fall: got %b expected %b", Fall, m_fall);
    end
    checks++;
    assert (!(Rise === 1'b1 && Fall === 1'b1)) else begin
      errors++; $error("FAIL both_pulses: rise %b fall %b expected not both 1", Rise, Fall);
    end
  endtask

  // Holds din with Enable high and returns the edge index (first edge that
  // samples din = 1) at which Out changes; 0 if it never does within 60.
  task automatic measure(input logic din, input int exp_n, input string tag);
    logic start;
    int   n;
    start = Out;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b1, din);
      if (Out !== start) begin n = i; break; end
    end
    checks++;
    assert (n == exp_n) else begin
      errors++; $error("FAIL %s latency: got edge %0d expected edge %0d", tag, n, exp_n);
    end
    $display("measure %s: Out changed at edge %0d", tag, n);
  endtask

  initial begin
    int n;
    logic start;
    int rise_seen;
    logic din;
    int hold;

    for (int k = 0; k < SS; k++) m_pipe[k] = 1'b0;

    // Reset with In high for three cycles, then the full press latency.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    measure(1'b1, 10, "reset_release");
    step(1'b0, 1'b1, 1'b1);

    // Clean press from a fresh reset.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    measure(1'b1, 10, "clean_press");
    step(1'b0, 1'b1, 1'b1);

    // Release from Out=1.
    measure(1'b0, 10, "release");
    step(1'b0, 1'b1, 1'b0);

    // Glitches: 6 cycles high then 6 low, five times.
    rise_seen = 0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 6; i++) begin step(1'b0, 1'b1, 1'b1); if (Rise) rise_seen++; end
      for (int i = 0; i < 6; i++) begin step(1'b0, 1'b1, 1'b0); if (Rise) rise_seen++; end
    end
    checks++;
    assert (Out === 1'b0 && rise_seen == 0) else begin
      errors++; $error("FAIL glitch: out %b rises %0d expected out 0 rises 0", Out, rise_seen);
    end
    $display("glitch: out %b rises %0d", Out, rise_seen);

    // Toggling every cycle never qualifies.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, i[0]);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Enable one cycle in four stretches latency to edge 32.
    n = 0;
    start = Out;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, (i % 4 == 0), 1'b1);
      if (Out !== start) begin n = i; break; end
    end
    checks++;
    assert (n == 32) else begin
      errors++; $error("FAIL enable_1in4 latency: got edge %0d expected edge 32", n);
    end
    $display("enable_1in4: Out changed at edge %0d", n);

    // Enable held low: no change however long In disagrees.
    measure(1'b0, 10, "release2");
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1);
    checks++;
    assert (Out === 1'b0) else begin
      errors++; $error("FAIL enable_low: out %b expected 0", Out);
    end
    $display("enable_low: out %b", Out);

    // Reset at the 6th edge of a press, then the full latency again.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    assert (Out === 1'b0) else begin
      errors++; $error("FAIL reset_mid: out %b expected 0", Out);
    end
    measure(1'b1, 10, "after_mid_reset");

    // Randomized segments checked cycle by cycle against the model.
    for (int seg = 0; seg < 60; seg++) begin
      din  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 20);
      for (int i = 0; i < hold; i++)
        step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), din);
    end
    $display("random: done, model out %b", m_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish within time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
